// File: rtl/btn_pkg.sv
// btn_pkg: shared types and helpers for the push-button debounce bank.
// Contents: btn_state_t (per-channel debounce FSM encoding), tmr_w() timer width helper.
// Imported by btn_debounce_ch and btn_debounce_bank.
package btn_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT_P  = 2'd1,
    PRESSED = 2'd2,
    WAIT_R  = 2'd3
  } btn_state_t;

  // Bits needed for a counter that must reach cyc-1.
  function automatic int tmr_w(input int cyc);
    return (cyc <= 2) ? 1 : $clog2(cyc);
  endfunction

endpackage

// File: rtl/btn_debounce_ch.sv
// btn_debounce_ch: one button channel -- synchroniser, debounce FSM, press/release strobes,
// wrapping press counter with even flag and, when BTN_LONGPRESS_EN is defined, a long-press strobe.
// Ports: clk, reset_n (async, active-low), sw (raw pin), clr (counter clear); level, press_pulse,
// release_pulse, long_pulse, cnt_sum[SUM_W], even.
module btn_debounce_ch
  import btn_pkg::*;
#(
  parameter int DEB_CYC     = 10_000_000,
  parameter int SUM_W       = 8,
  parameter int SYNC_STAGES = 2,
  parameter int LONG_CYC    = 100_000_000
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             sw,
  input  logic             clr,
  output logic             level,
  output logic             press_pulse,
  output logic             release_pulse,
  output logic             long_pulse,
  output logic [SUM_W-1:0] cnt_sum,
  output logic             even
);

  localparam int TW = tmr_w(DEB_CYC);
  localparam logic [TW-1:0] T_LAST = TW'(DEB_CYC - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;
  btn_state_t             state, next_state;
  logic [TW-1:0]          t;
  logic                   press_ev;
  logic                   release_ev;
  logic [SUM_W-1:0]       cnt_nxt;

  assign s = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) sync_q <= '0;
    else          sync_q <= {sync_q[SYNC_STAGES-2:0], sw};
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (s) next_state = WAIT_P;
      WAIT_P:  if (!s) next_state = IDLE;
               else if (t == T_LAST) next_state = PRESSED;
      PRESSED: if (!s) next_state = WAIT_R;
      WAIT_R:  if (s) next_state = PRESSED;
               else if (t == T_LAST) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  assign press_ev   = (state == WAIT_P) && (next_state == PRESSED);
  assign release_ev = (state == WAIT_R) && (next_state == IDLE);

  // Clear wins over a coincident increment.
  always_comb begin
    cnt_nxt = cnt_sum;
    if (clr)           cnt_nxt = '0;
    else if (press_ev) cnt_nxt = cnt_sum + 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      t             <= '0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      cnt_sum       <= '0;
      even          <= 1'b1;
    end else begin
      state <= next_state;
      // Any state change (including an abort) restarts the full window.
      if (next_state != state || state == IDLE || state == PRESSED) t <= '0;
      else                                                          t <= t + 1'b1;
      press_pulse   <= press_ev;
      release_pulse <= release_ev;
      cnt_sum       <= cnt_nxt;
      even          <= ~cnt_nxt[0];
    end
  end

  assign level = (state == PRESSED) || (state == WAIT_R);

`ifdef BTN_LONGPRESS_EN
  localparam int LW = tmr_w(LONG_CYC + 1);
  logic [LW-1:0] lt;

  // Saturating at LONG_CYC guarantees the strobe value is crossed once per press;
  // the timer holds through WAIT_R so a release bounce cannot re-arm it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                                   lt <= '0;
    else if (release_ev)                            lt <= '0;
    else if (state == PRESSED && lt != LW'(LONG_CYC)) lt <= lt + 1'b1;
  end

  assign long_pulse = (state == PRESSED) && (lt == LW'(LONG_CYC - 1));
`else
  // No long-press timer in this build; LONG_CYC has no effect.
  assign long_pulse = 1'b0 & (LONG_CYC != 0);
`endif

endmodule

// File: rtl/btn_debounce_bank.sv
// btn_debounce_bank: N_CH independent debounced push-button channels with strobes and press counters.
// Ports: clk, reset_n (async, active-low), sw/clr[N_CH]; level, press_pulse, release_pulse,
// long_pulse, even [N_CH]; cnt_sum[N_CH*SUM_W] (channel i at [i*SUM_W +: SUM_W]). Long press needs BTN_LONGPRESS_EN.
module btn_debounce_bank
  import btn_pkg::*;
#(
  parameter int N_CH        = 4,
  parameter int DEB_CYC     = 10_000_000,
  parameter int SUM_W       = 8,
  parameter int SYNC_STAGES = 2,
  parameter int LONG_CYC    = 100_000_000
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [N_CH-1:0]       sw,
  input  logic [N_CH-1:0]       clr,
  output logic [N_CH-1:0]       level,
  output logic [N_CH-1:0]       press_pulse,
  output logic [N_CH-1:0]       release_pulse,
  output logic [N_CH-1:0]       long_pulse,
  output logic [N_CH*SUM_W-1:0] cnt_sum,
  output logic [N_CH-1:0]       even
);

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    btn_debounce_ch #(
      .DEB_CYC     (DEB_CYC),
      .SUM_W       (SUM_W),
      .SYNC_STAGES (SYNC_STAGES),
      .LONG_CYC    (LONG_CYC)
    ) u_ch (
      .clk           (clk),
      .reset_n       (reset_n),
      .sw            (sw[i]),
      .clr           (clr[i]),
      .level         (level[i]),
      .press_pulse   (press_pulse[i]),
      .release_pulse (release_pulse[i]),
      .long_pulse    (long_pulse[i]),
      .cnt_sum       (cnt_sum[i*SUM_W +: SUM_W]),
      .even          (even[i])
    );
  end

endmodule

// File: tb/tb_btn_debounce_bank.sv
module tb_btn_debounce_bank;
  localparam int N_CH = 2;
  localparam int DEB_CYC = 8;
  localparam int SUM_W = 4;
  localparam int SYNC_STAGES = 2;
  localparam int LONG_CYC = 20;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic [N_CH-1:0] sw = '0;
  logic [N_CH-1:0] clr = '0;
  logic [N_CH-1:0] level, press_pulse, release_pulse, long_pulse, even;
  logic [N_CH*SUM_W-1:0] cnt_sum;

  btn_debounce_bank #(
    .N_CH(N_CH), .DEB_CYC(DEB_CYC), .SUM_W(SUM_W),
    .SYNC_STAGES(SYNC_STAGES), .LONG_CYC(LONG_CYC)
  ) dut (
    .clk(clk), .reset_n(reset_n), .sw(sw), .clr(clr),
    .level(level), .press_pulse(press_pulse), .release_pulse(release_pulse),
    .long_pulse(long_pulse), .cnt_sum(cnt_sum), .even(even)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Reference model: a level flips once the synchronised input has disagreed with it for
  // DEB_CYC+1 consecutive samples; any agreeing sample resets the run.
  bit m_sq [N_CH][SYNC_STAGES];
  bit m_lvl [N_CH];
  int m_run [N_CH];
  int m_lcnt [N_CH];
  int m_cnt [N_CH];
  bit m_press [N_CH];
  bit m_rel [N_CH];

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int c = 0; c < N_CH; c++) begin
        for (int k = 0; k < SYNC_STAGES; k++) m_sq[c][k] = 1'b0;
        m_lvl[c] = 0; m_run[c] = 0; m_lcnt[c] = 0; m_cnt[c] = 0;
        m_press[c] = 0; m_rel[c] = 0;
      end
    end else begin
      for (int c = 0; c < N_CH; c++) begin
        bit s;
        bit inc;
        s = m_sq[c][SYNC_STAGES-1];
        for (int k = SYNC_STAGES-1; k > 0; k--) m_sq[c][k] = m_sq[c][k-1];
        m_sq[c][0] = sw[c];
        m_press[c] = 0; m_rel[c] = 0; inc = 0;
        if (m_lvl[c] && m_run[c] == 0) m_lcnt[c]++;
        if (s != m_lvl[c]) m_run[c]++; else m_run[c] = 0;
        if (m_run[c] == DEB_CYC + 1) begin
          m_lvl[c] = !m_lvl[c];
          m_run[c] = 0;
          if (m_lvl[c]) begin m_press[c] = 1; inc = 1; end
          else begin m_rel[c] = 1; m_lcnt[c] = 0; end
        end
        if (clr[c]) m_cnt[c] = 0;
        else if (inc) m_cnt[c] = (m_cnt[c] + 1) % (1 << SUM_W);
      end
    end
  end

  function automatic bit m_long(input int c);
`ifdef BTN_LONGPRESS_EN
    return m_lvl[c] && m_run[c] == 0 && m_lcnt[c] == LONG_CYC - 1;
`else
    return 1'b0;
`endif
  endfunction

  int p_cnt [N_CH];
  int r_cnt [N_CH];
  int l_cnt [N_CH];
  initial for (int c = 0; c < N_CH; c++) begin p_cnt[c] = 0; r_cnt[c] = 0; l_cnt[c] = 0; end

  always @(negedge clk) begin
    if (reset_n) begin
      for (int c = 0; c < N_CH; c++) begin
        if (press_pulse[c]) p_cnt[c]++;
        if (release_pulse[c]) r_cnt[c]++;
        if (long_pulse[c]) l_cnt[c]++;
        if (chk_en) begin
          logic [8:0] got, exp;
          logic [SUM_W-1:0] mc;
          mc = SUM_W'(m_cnt[c]);
          got = {level[c], press_pulse[c], release_pulse[c], long_pulse[c],
                 cnt_sum[c*SUM_W +: SUM_W], even[c]};
          exp = {m_lvl[c], m_press[c], m_rel[c], m_long(c), mc, ~mc[0]};
          check($sformatf("model_ch%0d", c), 64'(got), 64'(exp));
        end
      end
    end
  end

  typedef struct { int hi; int exp_press; } vec_t;
  vec_t vecs [5];

  task automatic press(input int c, input int hi, input int lo);
    sw[c] = 1'b1; cyc(hi);
    sw[c] = 1'b0; cyc(lo);
  endtask

  initial begin
    int p0, r0, c0, l0;
    vecs[0] = '{4, 0};
    vecs[1] = '{8, 0};
    vecs[2] = '{9, 1};
    vecs[3] = '{10, 1};
    vecs[4] = '{25, 1};

    cyc(3);
    reset_n = 1'b1;
    chk_en = 1'b1;
    @(negedge clk);
    check("reset_outs", {level, press_pulse, release_pulse, long_pulse, cnt_sum, even},
          {2'b00, 2'b00, 2'b00, 2'b00, 8'h00, 2'b11});

    // Clean 40-cycle press on ch0: strobe latency and long press
    @(posedge clk); #1;
    sw[0] = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #2;
      check($sformatf("press_lat_k%0d", k), press_pulse[0], k == 11);
`ifdef BTN_LONGPRESS_EN
      check($sformatf("long_k%0d", k), long_pulse[0], k == 30);
`else
      check($sformatf("long_k%0d", k), long_pulse[0], 1'b0);
`endif
    end
    check("cnt0_after_press", cnt_sum[3:0], 4'd1);
    check("even0_after_press", even[0], 1'b0);
    check("ch1_idle", {level[1], cnt_sum[7:4], even[1]}, {1'b0, 4'd0, 1'b1});
    sw[0] = 1'b0; cyc(20);

    // Table: pulse width vs acceptance
    for (int i = 0; i < 5; i++) begin
      p0 = p_cnt[0]; r0 = r_cnt[0]; c0 = int'(cnt_sum[3:0]);
      press(0, vecs[i].hi, 20);
      check($sformatf("tbl_press_hi%0d", vecs[i].hi), p_cnt[0] - p0, vecs[i].exp_press);
      check($sformatf("tbl_rel_hi%0d", vecs[i].hi), r_cnt[0] - r0, vecs[i].exp_press);
      check($sformatf("tbl_cnt_hi%0d", vecs[i].hi), cnt_sum[3:0], 4'((c0 + vecs[i].exp_press) % 16));
    end

    // Release bounce inside WAIT_R
    p0 = p_cnt[0]; r0 = r_cnt[0];
    sw[0] = 1'b1; cyc(15);
    sw[0] = 1'b0; cyc(4);
    sw[0] = 1'b1; cyc(3);
    check("bounce_level_held", level[0], 1'b1);
    check("bounce_no_release", r_cnt[0] - r0, 0);
    sw[0] = 1'b0; cyc(20);
    check("bounce_one_release", r_cnt[0] - r0, 1);
    check("bounce_one_press", p_cnt[0] - p0, 1);

    // 16 presses on ch1 wrap the counter
    p0 = p_cnt[1];
    for (int i = 0; i < 16; i++) press(1, 12, 14);
    check("wrap_presses", p_cnt[1] - p0, 16);
    check("wrap_cnt1", cnt_sum[7:4], 4'd0);
    check("wrap_even1", even[1], 1'b1);
    // 17th press with clr on the increment cycle: clear wins
    sw[1] = 1'b1; cyc(10);
    clr[1] = 1'b1; cyc(1);
    clr[1] = 1'b0;
    check("clr_coinc_pulse", press_pulse[1], 1'b1);
    check("clr_coinc_cnt", cnt_sum[7:4], 4'd0);
    sw[1] = 1'b0; cyc(14);
    press(1, 12, 14);
    check("cnt1_after_clr", {cnt_sum[7:4], even[1]}, {4'd1, 1'b0});
    clr[1] = 1'b1; cyc(1); clr[1] = 1'b0;
    check("clr_alone", {cnt_sum[7:4], even[1]}, {4'd0, 1'b1});

    // Reset in the middle of a WAIT_P window
    p0 = p_cnt[0]; r0 = r_cnt[0]; l0 = l_cnt[0];
    sw[0] = 1'b1; cyc(6);
    reset_n = 1'b0; sw[0] = 1'b0; cyc(2);
    reset_n = 1'b1; cyc(20);
    check("rst_mid_no_strobe", {p_cnt[0] - p0, r_cnt[0] - r0, l_cnt[0] - l0}, 96'd0);
    check("rst_mid_state", {level[0], cnt_sum[3:0], even[0]}, {1'b0, 4'd0, 1'b1});

    // Random bouncy traffic on both channels against the model
    begin
      int hold [N_CH];
      for (int c = 0; c < N_CH; c++) hold[c] = 1;
      for (int n = 0; n < 3000; n++) begin
        for (int c = 0; c < N_CH; c++) begin
          hold[c]--;
          if (hold[c] == 0) begin
            sw[c] = ~sw[c];
            hold[c] = int'($urandom_range(1, 40));
          end
          clr[c] = ($urandom_range(0, 63) == 0);
        end
        cyc(1);
      end
      sw = '0; clr = '0;
      cyc(30);
    end
`ifndef BTN_LONGPRESS_EN
    check("no_long_ever", l_cnt[0] + l_cnt[1], 0);
`endif

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
